// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit carry-lookahead
// slice. It processes one nibble per clock, least significant nibble first.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  operand handshake (a, b, cin); in_ready is high only in IDLE
//   out_valid/ready result handshake; out_valid is high only in DONE
//   sum, cout       registered result, {cout,sum} = a + b + cin
//   overflow        signed overflow of the result
//
// Optional feature: define CLA_SER_OVF_EN to build the overflow flag.
// Without it, overflow is tied to 0.
module cla_nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               c_q, c_d, cout_q, cout_d;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  // Combinational nibble datapath signals
  logic [IDX_W+1:0]   nib_base;
  logic [3:0]         a_nib, b_nib, p, g, carry, s_nib;
  logic               grp_p, grp_g, c_next;
  logic               last_nib;

  // One 4-bit CLA slice on the current nibble. All carries come from lookahead terms.
  always_comb begin
    nib_base = {idx_q, 2'b00};
    a_nib    = a_q[nib_base +: 4];
    b_nib    = b_q[nib_base +: 4];
    p        = a_nib ^ b_nib;
    g        = a_nib & b_nib;
    carry[0] = c_q;
    carry[1] = g[0] | (p[0] & c_q);
    carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
    carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
    s_nib    = p ^ carry;
    grp_p    = &p;
    grp_g    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    c_next   = grp_g | (grp_p & c_q);
    last_nib = (idx_q == IDX_W'(NIB - 1));
  end

  // Next-state logic and register updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    c_d     = c_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[nib_base +: 4] = s_nib;
        c_d                  = c_next;
        idx_d                = idx_q + IDX_W'(1);
        if (last_nib) begin
          cout_d  = c_next;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      c_q         <= c_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef CLA_SER_OVF_EN
  // Signed overflow: the carry into the MSB differs from the carry out of the MSB.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) ovf_d = 1'b0;
    else if (state_q == RUN && last_nib) ovf_d = carry[3] ^ c_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Bench for cla_nibble_serial_adder. The driver pushes the arithmetic result
// a+b+cin for every accepted operand pair. The monitor compares the DUT
// result against the head of the queue, and checks result latency and hold
// stability.
module tb_cla_nibble_serial_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    longint       t;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, cin, out_valid, out_ready, cout, overflow;
  logic [W-1:0] a, b, sum;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;  // 0: random out_ready, 1: stall, 2: always ready
  logic prev_ov = 1'b0;

  cla_nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Call at a negedge. Returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                      output int waited);
    exp_t       e;
    logic [W:0] full;
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; waited = 0;
    while (!in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready still low after %0d cycles", waited);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    full = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
    e.s  = full[W-1:0];
    e.co = full[W];
`ifdef CLA_SER_OVF_EN
    e.ov = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
`else
    e.ov = 1'b0;
`endif
    e.t  = longint'($time);
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: check any presented result, then drive out_ready for the next edge.
  always @(negedge clk) begin
    exp_t   e;
    longint dt;
    if (rst) begin
      prev_ov   = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: sum=%0h cout=%0b with empty queue", sum, cout);
        end else begin
          e = q[0];
          checks++;
          if (sum !== e.s || cout !== e.co || overflow !== e.ov) begin
            errors++;
            $display("FAIL result: got sum=%0h cout=%0b ovf=%0b expected sum=%0h cout=%0b ovf=%0b",
                     sum, cout, overflow, e.s, e.co, e.ov);
          end
          if (!prev_ov) begin
            dt = longint'($time) - e.t;
            chk("latency", 64'(dt), 64'(NIB * 10 + 5));
          end
        end
      end
      prev_ov = out_valid;
      case (mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  initial begin
    int w, n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Wrap to zero with a carry out.
    send(16'hFFFF, 16'h0001, 1'b0, w);

    // A second in_valid pulse during RUN must be ignored.
    send(16'h1234, 16'h4321, 1'b1, w);
    chk("run_in_ready_low", 64'(in_ready), 64'd0);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_after_ignore", 64'(q.size()), 64'd0);

    // Back-pressure: DONE holds while out_ready is low.
    @(posedge clk); #1 mode = 1;
    @(negedge clk);
    send(16'hBEEF, 16'h1357, 1'b0, w);
    repeat (NIB) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    send(16'h0102, 16'h0304, 1'b1, w);
    chk("bp_accept_no_wait", 64'(w), 64'd0);
    @(posedge clk); #1 mode = 0;
    @(negedge clk);

    // Reset during RUN discards the operation.
    send(16'hAAAA, 16'h5555, 1'b0, w);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    send(16'h0F0F, 16'h00F1, 1'b0, w);

    // Signed overflow cases.
    send(16'h7FFF, 16'h0001, 1'b0, w);
    send(16'h8000, 16'h8000, 1'b0, w);

    // Random regression with random stalls and gaps.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(W'({$urandom, $urandom}), W'({$urandom, $urandom}), 1'($urandom), w);
    end

    n = 0;
    while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    @(posedge clk); #1 mode = 2;
    repeat (5) @(negedge clk);
    chk("final_queue_empty", 64'(q.size()), 64'd0);
    chk("final_idle_in_ready", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
